// File: rtl/axis_src_pkg.sv
// Shared types, constants and LFSR helpers for the AXI4-Stream test pattern source.
package axis_src_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_RAMP    = 2'd0,
        MODE_CONST   = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_t;

    localparam int PIX_W        = 8;
    localparam int PIX_PER_BEAT = 4;
    localparam int BEAT_W       = PIX_W * PIX_PER_BEAT;

    localparam logic [BEAT_W-1:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [BEAT_W-1:0] CHK_EVEN  = 32'h00FF_00FF;
    localparam logic [BEAT_W-1:0] CHK_ODD   = 32'hFF00_FF00;

    // One Galois step: shift right, fold the taps back in when a 1 falls out.
    function automatic logic [BEAT_W-1:0] lfsr_step(input logic [BEAT_W-1:0] s);
        logic [BEAT_W-1:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ LFSR_TAPS;
        end
        return r;
    endfunction

    // An all-zero LFSR would lock up, so a zero seed starts from 1 instead.
    function automatic logic [BEAT_W-1:0] lfsr_seed(input logic [BEAT_W-1:0] s);
        return (s == '0) ? {{(BEAT_W-1){1'b0}}, 1'b1} : s;
    endfunction

endpackage

// File: rtl/pattern_word_gen.sv
// Combinational beat generator: produces the word for a given beat index and
// the LFSR state that goes with it.
module pattern_word_gen
    import axis_src_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  mode_t             mode,
    input  logic [LEN_W-1:0]  beat_idx,
    input  logic [BEAT_W-1:0] seed,
    input  logic [BEAT_W-1:0] lfsr_state,
    output logic [BEAT_W-1:0] word,
    output logic [BEAT_W-1:0] lfsr_next
);

    // Pattern select; RAMP only needs the low 6 index bits since 64 beats cover 256 pixel values.
    always_comb begin
        word      = '0;
        lfsr_next = lfsr_state;
        case (mode)
            MODE_RAMP: begin
                for (int k = 0; k < PIX_PER_BEAT; k++) begin
                    word[k*PIX_W +: PIX_W] = {beat_idx[5:0], 2'(k)};
                end
            end
            MODE_CONST: begin
                word = seed;
            end
            MODE_LFSR: begin
                if (beat_idx == '0) begin
                    word = lfsr_seed(seed);
                end else begin
                    word = lfsr_step(lfsr_state);
                end
                lfsr_next = word;
            end
            MODE_CHECKER: begin
                word = beat_idx[0] ? CHK_ODD : CHK_EVEN;
            end
            default: begin
                word = '0;
            end
        endcase
    end

endmodule

// File: rtl/axis_pattern_source.sv
// AXI4-Stream master emitting fixed-length test frames (RAMP/CONST/LFSR/CHECKER).
//
//   state | meaning
//   IDLE  | waiting for start; frame parameters latched on start
//   SEND  | beats presented, one per handshake; last beat flagged
//   DONE  | frame finished; done pulses for one cycle, then back to IDLE
module axis_pattern_source
    import axis_src_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 16
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [LEN_W-1:0]      num_beats,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready
);

    localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t                state;
    mode_t                 mode_q;
    logic [LEN_W-1:0]      num_q;
    logic [LEN_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [DATA_WIDTH-1:0] lfsr_q;

    logic                  handshake;
    logic [LEN_W-1:0]      idx_next;
    mode_t                 gen_mode;
    logic [LEN_W-1:0]      gen_idx;
    logic [DATA_WIDTH-1:0] gen_seed;
    logic [DATA_WIDTH-1:0] gen_word;
    logic [DATA_WIDTH-1:0] gen_lfsr_next;

    assign handshake = m_axis_valid && m_axis_ready;
    assign idx_next  = idx_q + ONE;

    // In IDLE the generator looks at the live inputs to build beat 0; afterwards it uses the latched copies.
    always_comb begin
        gen_mode = mode_q;
        gen_idx  = idx_next;
        gen_seed = seed_q;
        if (state == IDLE) begin
            gen_mode = mode_t'(mode);
            gen_idx  = '0;
            gen_seed = seed;
        end
    end

    pattern_word_gen #(
        .LEN_W(LEN_W)
    ) u_gen (
        .mode       (gen_mode),
        .beat_idx   (gen_idx),
        .seed       (gen_seed),
        .lfsr_state (lfsr_q),
        .word       (gen_word),
        .lfsr_next  (gen_lfsr_next)
    );

    // Frame FSM with all stream and status outputs registered.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state        <= IDLE;
            mode_q       <= MODE_RAMP;
            num_q        <= '0;
            idx_q        <= '0;
            seed_q       <= '0;
            lfsr_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (num_beats != '0) begin
                            mode_q       <= mode_t'(mode);
                            num_q        <= num_beats;
                            seed_q       <= seed;
                            idx_q        <= '0;
                            lfsr_q       <= gen_lfsr_next;
                            m_axis_valid <= 1'b1;
                            m_axis_data  <= gen_word;
                            m_axis_last  <= (num_beats == ONE);
                            state        <= SEND;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (m_axis_last) begin
                            m_axis_valid <= 1'b0;
                            m_axis_last  <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            state        <= DONE;
                        end else begin
                            idx_q       <= idx_next;
                            lfsr_q      <= gen_lfsr_next;
                            m_axis_data <= gen_word;
                            m_axis_last <= (idx_next == num_q - ONE);
                        end
                    end
                end
                DONE: begin
                    // A zero-length frame arrives here with done still low and busy high,
                    // so it spends one extra cycle raising done.
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_source.sv
// Scoreboard bench for axis_pattern_source: frames are modelled from the pattern
// rules, queued as expected beats, and a monitor pops them on every handshake.
module tb_axis_pattern_source;

    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] num_beats = 16'd0;
    logic [31:0] seed = 32'd0;
    logic        busy, done, valid, last;
    logic [31:0] data;
    logic        ready = 1'b0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    bit    ready_pat[$];
    int    ready_mode = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    hs_count = 0;
    bit    exp_done_next = 1'b0;
    bit    zero_active = 1'b0;

    axis_pattern_source #(.DATA_WIDTH(32), .LEN_W(16)) dut (
        .axi_clk      (clk),
        .axi_reset_n  (rst_n),
        .start        (start),
        .mode         (mode),
        .num_beats    (num_beats),
        .seed         (seed),
        .busy         (busy),
        .done         (done),
        .m_axis_valid (valid),
        .m_axis_data  (data),
        .m_axis_last  (last),
        .m_axis_ready (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beat words straight from the pattern definitions.
    task automatic push_frame(input int m, input int n, input logic [31:0] sd);
        logic [31:0] s;
        logic [31:0] w;
        beat_t       e;
        s = (sd == 32'd0) ? 32'd1 : sd;
        for (int b = 0; b < n; b++) begin
            w = 32'd0;
            case (m)
                0: for (int l = 0; l < 4; l++) w[8*l +: 8] = 8'((4*b + l) % 256);
                1: w = sd;
                2: begin
                    w = s;
                    s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
                end
                default: w = (b % 2 == 0) ? 32'h00FF00FF : 32'hFF00FF00;
            endcase
            e.data = w;
            e.last = (b == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Ready driver: a queued pattern (advanced only while valid) takes priority over the mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_pat.size() > 0) begin
                if (valid) ready = ready_pat.pop_front();
                else ready = 1'b0;
            end else if (ready_mode == 0) begin
                ready = 1'b1;
            end else begin
                ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compares every handshake against the scoreboard and checks hold/done behaviour.
    initial begin
        bit          hold_pending;
        logic [31:0] held_data;
        logic        held_last;
        beat_t       e;
        hold_pending = 1'b0;
        held_data = 32'd0;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pending  = 1'b0;
                exp_done_next = 1'b0;
            end else begin
                if ((done || exp_done_next) && !zero_active)
                    check(done === exp_done_next, "done_timing", 32'(done), 32'(exp_done_next));
                exp_done_next = 1'b0;
                if (hold_pending) begin
                    check(valid === 1'b1 && data === held_data && last === held_last,
                          "hold_stable", data, held_data);
                    hold_pending = 1'b0;
                end
                if (valid) check(busy === 1'b1, "busy_during_valid", 32'(busy), 32'd1);
                if (valid && ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_beat", data, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check(data === e.data, "beat_data", data, e.data);
                        check(last === e.last, "beat_last", 32'(last), 32'(e.last));
                        if (e.last) exp_done_next = 1'b1;
                    end
                end else if (valid) begin
                    hold_pending = 1'b1;
                    held_data    = data;
                    held_last    = last;
                end
            end
        end
    end

    task automatic issue_start(input int m, input int n, input logic [31:0] sd);
        @(posedge clk);
        #1;
        mode      = 2'(m);
        num_beats = 16'(n);
        seed      = sd;
        start     = 1'b1;
        zero_active = (n == 0);
        @(posedge clk);
        #1;
        start     = 1'b0;
        mode      = 2'($urandom);
        num_beats = 16'($urandom);
        seed      = $urandom;
    endtask

    task automatic run_frame(input int m, input int n, input logic [31:0] sd, input bit timed, input bit poke);
        int hs0;
        int el;
        int budget;
        push_frame(m, n, sd);
        hs0 = hs_count;
        budget = 30 * n + 20;
        issue_start(m, n, sd);
        @(negedge clk);
        check(busy === 1'b1, "busy_after_start", 32'(busy), 32'd1);
        el = 1;
        while (!done && el < budget) begin
            if (poke && el == 2) begin
                start = 1'b1;
                num_beats = 16'd1;
                mode = 2'd1;
            end
            if (poke && el == 3) start = 1'b0;
            @(negedge clk);
            el++;
        end
        start = 1'b0;
        check(done === 1'b1, "done_seen", 32'(el), 32'(budget));
        if (timed) check(el == ((n > 0) ? n + 1 : 2), "done_latency", 32'(el), 32'((n > 0) ? n + 1 : 2));
        check(busy === 1'b0, "busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check(done === 1'b0, "done_one_cycle", 32'(done), 32'd0);
        check(exp_q.size() == 0, "frame_beats_consumed", 32'(exp_q.size()), 32'd0);
        check(hs_count - hs0 == n, "handshake_count", 32'(hs_count - hs0), 32'(n));
        exp_q.delete();
        zero_active = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int cnt;
        int rm;
        int rn;
        logic [31:0] rs;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(valid === 1'b0, "reset_valid", 32'(valid), 32'd0);
        check(last === 1'b0, "reset_last", 32'(last), 32'd0);
        check(busy === 1'b0, "reset_busy", 32'(busy), 32'd0);
        check(done === 1'b0, "reset_done", 32'(done), 32'd0);
        check(data === 32'd0, "reset_data", data, 32'd0);
        rst_n = 1'b1;

        ready_mode = 0;
        run_frame(0, 4, 32'd0, 1'b1, 1'b0);
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_frame(0, 3, 32'd0, 1'b0, 1'b0);
        run_frame(3, 2, 32'd0, 1'b1, 1'b0);
        run_frame(2, 4, 32'd0, 1'b1, 1'b0);
        run_frame(0, 0, 32'd0, 1'b1, 1'b0);
        run_frame(0, 70, 32'd0, 1'b1, 1'b0);
        run_frame(1, 5, 32'hDEADBEEF, 1'b1, 1'b0);
        run_frame(3, 1, 32'd0, 1'b1, 1'b0);
        run_frame(0, 8, 32'd0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check(valid === 1'b0, "no_frame_from_ignored_start", 32'(valid), 32'd0);

        // Reset in the middle of an 8-beat RAMP frame, while beat 2 is presented.
        push_frame(0, 8, 32'd0);
        hs0 = hs_count;
        issue_start(0, 8, 32'd0);
        cnt = 0;
        while (hs_count - hs0 < 2 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check(hs_count - hs0 == 2, "reach_beat2", 32'(hs_count - hs0), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check(valid === 1'b0, "async_reset_valid", 32'(valid), 32'd0);
        check(busy === 1'b0, "async_reset_busy", 32'(busy), 32'd0);
        check(data === 32'd0, "async_reset_data", data, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 4, 32'd0, 1'b1, 1'b0);

        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            rm = $urandom_range(0, 3);
            rn = $urandom_range(0, 20);
            rs = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_frame(rm, rn, rs, 1'b0, (rn > 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
